ucsbece152a_mod_counter: RTL and testbench
==========================================

Name: ucsbece152a_mod_counter

Overview:
Parametrised modulo up/down counter. Next generation of the lab counter: it adds a programmable terminal value (MAX), a clock prescaler, parallel load, and a runtime wrap/saturate mode. It also provides a terminal-count flag and a wrap-event pulse. It drives timers and sequencers in the lab datapath.

Parameters:
WIDTH, 3, counter width in bits.
MAX, 2**WIDTH-1, terminal value; count range is 0..MAX; legal range 1 <= MAX <= 2**WIDTH-1.
PRESCALE, 1, number of enabled cycles per count step; legal range >= 1.
RST_VAL, 0, count value after reset; legal range <= MAX.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  asynchronous, active-high reset.
enable_i  input  1  count enable; low holds the count and the prescaler phase.
dir_i  input  1  count direction; 0 = up, 1 = down.
load_i  input  1  synchronous parallel load.
load_val_i  input  WIDTH  load value.
sat_i  input  1  end-of-range mode; 0 = wrap, 1 = saturate.
count_o  output  WIDTH  current count (registered).
tc_o  output  1  terminal count flag (combinational from count_o and dir_i).
wrap_o  output  1  one-cycle pulse, registered alongside count_o.

Behaviour:
- Reset: clk and rst are a single clock with asynchronous, active-high reset. While rst=1, independent of clk:
  - count_o=RST_VAL, wrap_o=0, prescaler phase=0.
  - After release, first change is at the next posedge.
- Priority at each posedge: rst > load_i > step > hold.
- Load:
  - load_i=1 sets count_o <= (load_val_i > MAX) ? MAX : load_val_i.
  - Prescaler phase <= 0, wrap_o <= 0.
  - Load ignores enable_i, dir_i and sat_i.
- Prescaler:
  - Counts cycles with enable_i=1 from 0 to PRESCALE-1, then returns to 0.
  - tick = enable_i && (phase == PRESCALE-1).
  - PRESCALE=1 gives tick = enable_i (same behaviour as the previous counter).
  - When enable_i=0, phase holds.
- Step (on tick, no load):
  - Up: count<MAX gives count+1. count==MAX gives 0 with wrap_o<=1 when sat_i=0, or holds MAX with wrap_o<=0 when sat_i=1.
  - Down: count>0 gives count-1. count==0 gives MAX with wrap_o<=1 when sat_i=0, or holds 0 when sat_i=1.
- wrap_o is high for exactly the one cycle in which count_o first shows the wrapped value; otherwise it is 0.
- tc_o = (dir_i==0 && count_o==MAX) || (dir_i==1 && count_o==0). It follows dir_i immediately.
- Changes to dir_i or sat_i take effect at the next step; there is no pipeline.
- Count arithmetic is WIDTH bits. count_o never exceeds MAX, including when WIDTH-bit overflow is possible (MAX = 2**WIDTH-1).
- Illegal parameter values (MAX, PRESCALE, RST_VAL outside the ranges above) raise an elaboration-time $error.

Optional Feature:
UCSBECE152A_COUNTER_EVCNT_EN:
- Defined: adds output wraps_o [7:0], which counts wrap_o pulses.
  - Saturates at 255.
  - Cleared only by rst; unaffected by load_i.
- Undefined: wraps_o port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ucsbece152a_counter_pkg:
  - typedef enum logic {DIR_UP=1'b0, DIR_DOWN=1'b1} dir_e.
  - typedef enum logic {MODE_WRAP=1'b0, MODE_SAT=1'b1} mode_e.
  - Function presc_w(PRESCALE) returning $clog2 width, minimum 1.
- One sub-module, ucsbece152a_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst, enable_i, clear_i, tick_o.
  - clear_i is driven by load_i.

Test Plan:
- WIDTH=3, MAX=5, PRESCALE=1, sat_i=0, dir_i=0, enable_i=1 for 8 cycles after reset -> count_o 0,1,2,3,4,5,0,1. wrap_o=1 only in the cycle showing 0 after 5. tc_o=1 while count_o=5.
- Load 2, then dir_i=1, sat_i=1, enable_i=1 for 4 cycles -> count_o 2,1,0,0,0. tc_o=1 at 0. wrap_o never asserted.
- Load behaviour:
  - load_val_i=7 with MAX=5 -> count_o=5.
  - load_i=1 with enable_i=0 -> value loaded.
  - load_i=1 with enable_i=1 at count 3, load_val_i=1 -> count_o=1 (load wins).
- PRESCALE=3, enable_i held high -> count_o 0,0,0,1,1,1,2.
  - Then drop enable_i for 2 cycles at phase 1 -> count holds. On re-enable, the step occurs after exactly 2 more enabled cycles.
- Async reset mid-operation: at count_o=4, assert rst between clock edges -> count_o=RST_VAL and wrap_o=0 before the next posedge. After release at negedge, counting resumes 0,1,...
- With UCSBECE152A_COUNTER_EVCNT_EN defined, MAX=2, wrap mode, 10 enabled cycles up -> wraps_o=3. With sat_i=1 -> wraps_o unchanged.

Source files
------------

// File: rtl/ucsbece152a_counter_pkg.sv
// ============================================================================
// Module  : ucsbece152a_counter_pkg
// Brief   : Shared types and helpers for the modulo counter and its prescaler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ucsbece152a_counter_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  // Phase register width for a prescaler of the given ratio (never zero bits).
  function automatic int presc_w(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ucsbece152a_prescaler.sv
// ============================================================================
// Module  : ucsbece152a_prescaler
// Brief   : Divides enabled cycles by PRESCALE, emitting a one-cycle tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ucsbece152a_prescaler
  import ucsbece152a_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int                     c_phase_w = presc_w(PRESCALE);
  localparam logic [c_phase_w-1:0]   c_last    = c_phase_w'(PRESCALE - 1);

  logic [c_phase_w-1:0] r_phase;
  logic                 w_last;

  assign w_last = (r_phase == c_last);
  assign tick_o = enable_i && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (clear_i) begin
      r_phase <= '0;
    end else if (enable_i) begin
      r_phase <= w_last ? '0 : r_phase + c_phase_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ucsbece152a_mod_counter.sv
// ============================================================================
// Module  : ucsbece152a_mod_counter
// Brief   : Modulo-MAX up/down counter with prescaler, load and wrap/saturate.
//           Define UCSBECE152A_COUNTER_EVCNT_EN to add the wraps_o event count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ucsbece152a_mod_counter
  import ucsbece152a_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o
`ifdef UCSBECE152A_COUNTER_EVCNT_EN
  ,
  output logic [7:0]       wraps_o
`endif
);

  if (MAX < 1 || MAX > (2**WIDTH) - 1) begin : g_bad_max
    $error("ucsbece152a_mod_counter: MAX=%0d out of range for WIDTH=%0d", MAX, WIDTH);
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("ucsbece152a_mod_counter: PRESCALE=%0d must be >= 1", PRESCALE);
  end
  if (RST_VAL < 0 || RST_VAL > MAX) begin : g_bad_rst_val
    $error("ucsbece152a_mod_counter: RST_VAL=%0d exceeds MAX=%0d", RST_VAL, MAX);
  end

  localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_tick;
  dir_e             w_dir;
  mode_e            w_mode;

  assign w_dir  = dir_e'(dir_i);
  assign w_mode = mode_e'(sat_i);

  ucsbece152a_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .clear_i  (load_i),
    .tick_o   (w_tick)
  );

  // End-of-range is detected by equality, so the WIDTH-bit +1/-1 never overflows.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (load_i) begin
      w_next = (load_val_i > c_max) ? c_max : load_val_i;
    end else if (w_tick) begin
      if (w_dir == DIR_UP) begin
        if (r_count != c_max) begin
          w_next = r_count + WIDTH'(1);
        end else if (w_mode == MODE_WRAP) begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_next = r_count - WIDTH'(1);
        end else if (w_mode == MODE_WRAP) begin
          w_next = c_max;
          w_wrap = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_rst_val;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap;
    end
  end

  assign count_o = r_count;
  assign wrap_o  = r_wrap;
  assign tc_o    = ((w_dir == DIR_UP)   && (r_count == c_max)) ||
                   ((w_dir == DIR_DOWN) && (r_count == '0));

`ifdef UCSBECE152A_COUNTER_EVCNT_EN
  logic [7:0] r_wraps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wraps <= '0;
    end else if (r_wrap && (r_wraps != 8'hFF)) begin
      r_wraps <= r_wraps + 8'd1;
    end
  end

  assign wraps_o = r_wraps;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ucsbece152a_mod_counter.sv
// ============================================================================
// Module  : tb_ucsbece152a_mod_counter
// Brief   : Directed self-checking bench for ucsbece152a_mod_counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ucsbece152a_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       ld;
  logic [2:0] ldv;
  logic       sat;

  int nvec = 0;
  int nerr = 0;

  // a: MAX=5 PRESCALE=1, p: MAX=5 PRESCALE=3, f: full range MAX=7
  logic [2:0] ca, cp, cf;
  logic       tca, tcp, tcf;
  logic       wa, wp, wf;
`ifdef UCSBECE152A_COUNTER_EVCNT_EN
  logic [2:0] ce;
  logic       tce, we;
  logic [7:0] wra, wrp, wrf, wre;
`endif

  always #5 clk = ~clk;

  ucsbece152a_mod_counter #(.WIDTH(3), .MAX(5), .PRESCALE(1), .RST_VAL(0)) u_a (
    .clk(clk), .rst(rst), .enable_i(en), .dir_i(dir), .load_i(ld),
    .load_val_i(ldv), .sat_i(sat), .count_o(ca), .tc_o(tca), .wrap_o(wa)
`ifdef UCSBECE152A_COUNTER_EVCNT_EN
    , .wraps_o(wra)
`endif
  );

  ucsbece152a_mod_counter #(.WIDTH(3), .MAX(5), .PRESCALE(3), .RST_VAL(0)) u_p (
    .clk(clk), .rst(rst), .enable_i(en), .dir_i(dir), .load_i(ld),
    .load_val_i(ldv), .sat_i(sat), .count_o(cp), .tc_o(tcp), .wrap_o(wp)
`ifdef UCSBECE152A_COUNTER_EVCNT_EN
    , .wraps_o(wrp)
`endif
  );

  ucsbece152a_mod_counter #(.WIDTH(3)) u_f (
    .clk(clk), .rst(rst), .enable_i(en), .dir_i(dir), .load_i(ld),
    .load_val_i(ldv), .sat_i(sat), .count_o(cf), .tc_o(tcf), .wrap_o(wf)
`ifdef UCSBECE152A_COUNTER_EVCNT_EN
    , .wraps_o(wrf)
`endif
  );

`ifdef UCSBECE152A_COUNTER_EVCNT_EN
  ucsbece152a_mod_counter #(.WIDTH(3), .MAX(2), .PRESCALE(1), .RST_VAL(0)) u_e (
    .clk(clk), .rst(rst), .enable_i(en), .dir_i(dir), .load_i(ld),
    .load_val_i(ldv), .sat_i(sat), .count_o(ce), .tc_o(tce), .wrap_o(we),
    .wraps_o(wre)
  );
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_a [7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_wa[7] = '{0, 0, 0, 0, 0, 1, 0};
  int exp_ta[7] = '{0, 0, 0, 0, 1, 0, 0};
  int exp_p [7] = '{0, 0, 1, 1, 1, 2, 2};
  int exp_f [7] = '{1, 2, 3, 4, 5, 6, 7};

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; ldv = 3'd0; sat = 1'b0;
    #12;
    chk("reset_count", 8'(ca), 8'd0);
    chk("reset_wrap",  8'(wa), 8'd0);
    chk("reset_tc",    8'(tca), 8'd0);
    chk("reset_count_p", 8'(cp), 8'd0);

    // Free-running up count in wrap mode
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("up_count", 8'(ca), 8'(exp_a[i]));
      chk("up_wrap",  8'(wa), 8'(exp_wa[i]));
      chk("up_tc",    8'(tca), 8'(exp_ta[i]));
      chk("presc3_count", 8'(cp), 8'(exp_p[i]));
      chk("full_count", 8'(cf), 8'(exp_f[i]));
    end
    chk("full_tc_at_7", 8'(tcf), 8'd1);
    step();
    chk("full_wrap_count", 8'(cf), 8'd0);
    chk("full_wrap_pulse", 8'(wf), 8'd1);
    chk("a_after_8", 8'(ca), 8'd2);

    // Load 2 then count down in saturate mode
    ld = 1'b1; ldv = 3'd2;
    step();
    chk("load2_count", 8'(ca), 8'd2);
    ld = 1'b0; dir = 1'b1; sat = 1'b1;
    step(); chk("down_sat_1", 8'(ca), 8'd1); chk("down_sat_w1", 8'(wa), 8'd0);
    step(); chk("down_sat_0", 8'(ca), 8'd0); chk("down_tc_0",  8'(tca), 8'd1);
    step(); chk("down_sat_hold0", 8'(ca), 8'd0); chk("down_sat_w3", 8'(wa), 8'd0);
    step(); chk("down_sat_hold1", 8'(ca), 8'd0); chk("down_sat_w4", 8'(wa), 8'd0);
    dir = 1'b0;
    #1;
    chk("tc_follows_dir", 8'(tca), 8'd0);

    // Load above MAX clamps; load works with enable low
    ld = 1'b1; ldv = 3'd7; en = 1'b0; sat = 1'b0;
    step();
    chk("load_clamp", 8'(ca), 8'd5);
    chk("tc_at_max", 8'(tca), 8'd1);
    ld = 1'b0; en = 1'b1;
    step();
    chk("wrap_from_load", 8'(ca), 8'd0);
    chk("wrap_pulse_load", 8'(wa), 8'd1);
    ld = 1'b1; ldv = 3'd3;
    step();
    chk("load3_count", 8'(ca), 8'd3);
    chk("load_clears_wrap", 8'(wa), 8'd0);
    ldv = 3'd1;
    step();
    chk("load_beats_step", 8'(ca), 8'd1);

    // Down wrap from 0 to MAX
    ld = 1'b1; ldv = 3'd0;
    step();
    ld = 1'b0; dir = 1'b1;
    step();
    chk("down_wrap_count", 8'(ca), 8'd5);
    chk("down_wrap_pulse", 8'(wa), 8'd1);

    // Saturate holds MAX going up
    ld = 1'b1; ldv = 3'd5; dir = 1'b0;
    step();
    ld = 1'b0; sat = 1'b1;
    step();
    chk("up_sat_hold", 8'(ca), 8'd5);
    chk("up_sat_nowrap", 8'(wa), 8'd0);

    // Asynchronous reset between edges at count 4
    ld = 1'b1; ldv = 3'd4; sat = 1'b0;
    step();
    chk("pre_rst_count", 8'(ca), 8'd4);
    ld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 8'(ca), 8'd0);
    chk("async_rst_wrap",  8'(wa), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("resume_a1", 8'(ca), 8'd1);
    chk("resume_p1", 8'(cp), 8'd0);

    // Prescaler pause at phase 1
    en = 1'b0;
    step(); step();
    chk("pause_p", 8'(cp), 8'd0);
    chk("pause_a", 8'(ca), 8'd1);
    en = 1'b1;
    step();
    chk("reen_p_first", 8'(cp), 8'd0);
    chk("reen_a_first", 8'(ca), 8'd2);
    step();
    chk("reen_p_second", 8'(cp), 8'd1);

`ifdef UCSBECE152A_COUNTER_EVCNT_EN
    // Wrap event counter on MAX=2
    rst = 1'b1; dir = 1'b0; sat = 1'b0; en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("evcnt_count", 8'(ce), 8'd1);
    chk("evcnt_wraps", wre, 8'd3);
    sat = 1'b1;
    step(); step(); step();
    chk("evcnt_sat_count", 8'(ce), 8'd2);
    chk("evcnt_sat_wraps", wre, 8'd3);
    ld = 1'b1; ldv = 3'd0;
    step();
    chk("evcnt_load_keeps", wre, 8'd3);
    ld = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
